byte_striper_n: RTL and testbench

Parametrised byte striper for the lane-distribution path. A serial stream of DATA_W-bit words is spread round-robin over up to LANES lanes, and each lane output is registered. It generalises the fixed four-lane, 8-bit striper with three additions:
- the number of active lanes is selectable at run time;
- a flush input realigns the stream to lane 0;
- group-complete and partial-group status pulses are produced.

---
 rtl/byte_striper_n_pkg.sv | 18 +
 rtl/byte_striper_n_lane_reg.sv | 32 +++
 rtl/byte_striper_n.sv | 88 ++++++++
 tb/tb_byte_striper_n.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/byte_striper_n_pkg.sv
`default_nettype none
// ============================================================================
// Module      : byte_striper_n_pkg
// Description : Constants and lane-count clamp shared by the striper/unstriper.
// Revision    : 1.0 - initial release
// ============================================================================
package byte_striper_n_pkg;

    localparam int c_default_data_w = 8;
    localparam int c_default_lanes  = 4;

    // Zero or oversize requests fall back to the full physical lane count.
    function automatic int clamp_lanes(input int req, input int lanes);
        return (req == 0 || req > lanes) ? lanes : req;
    endfunction

endpackage
`default_nettype wire

// File: rtl/byte_striper_n_lane_reg.sv
`default_nettype none
// ============================================================================
// Module      : byte_striper_n_lane_reg
// Description : One lane output register with write-enable and async reset.
// Revision    : 1.0 - initial release
// ============================================================================
module byte_striper_n_lane_reg
    import byte_striper_n_pkg::*;
#(
    parameter int DATA_W = c_default_data_w
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_we,
    input  logic [DATA_W-1:0] i_d,
    output logic [DATA_W-1:0] o_q
);

    logic [DATA_W-1:0] r_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_q <= '0;
        end else if (i_we) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule
`default_nettype wire

// File: rtl/byte_striper_n.sv
`default_nettype none
// ============================================================================
// Module      : byte_striper_n
// Description : Round-robin striper of a word stream over a run-time lane count.
// Revision    : 1.0 - initial release
// ============================================================================
module byte_striper_n
    import byte_striper_n_pkg::*;
#(
    parameter int DATA_W = c_default_data_w,
    parameter int LANES  = c_default_lanes,
    parameter int PTR_W  = (LANES > 1) ? $clog2(LANES) : 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    valid_in,
    input  logic [DATA_W-1:0]       data_in,
    input  logic [PTR_W:0]          active_lanes,
    input  logic                    flush,
    output logic [LANES*DATA_W-1:0] data_out,
    output logic [LANES-1:0]        valid_out,
    output logic [PTR_W-1:0]        lane_ptr,
    output logic                    group_done,
    output logic                    partial
);

    localparam logic [PTR_W:0]   c_lanes    = (PTR_W+1)'(LANES);
    localparam logic [PTR_W:0]   c_cnt_one  = (PTR_W+1)'(1);
    localparam logic [PTR_W-1:0] c_ptr_one  = PTR_W'(1);
    localparam logic [LANES-1:0] c_lane_one = LANES'(1);

    logic [PTR_W-1:0] r_ptr;
    logic [PTR_W:0]   r_n;
    logic [LANES-1:0] r_valid_out;
    logic             r_group_done;
    logic             r_partial;

    logic [PTR_W:0]   w_req_n;
    logic [PTR_W:0]   w_n;
    logic             w_last;
    logic [PTR_W-1:0] w_post;
    logic [LANES-1:0] w_onehot;

    assign w_req_n = (PTR_W+1)'(clamp_lanes(int'(active_lanes), LANES));

    // The lane count only follows the request at a group boundary, and the
    // boundary word itself already uses the newly sampled count.
    assign w_n      = (r_ptr == '0) ? w_req_n : r_n;
    assign w_last   = ({1'b0, r_ptr} == (w_n - c_cnt_one));
    assign w_post   = valid_in ? (w_last ? '0 : (r_ptr + c_ptr_one)) : r_ptr;
    assign w_onehot = valid_in ? (c_lane_one << r_ptr) : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ptr        <= '0;
            r_n          <= c_lanes;
            r_valid_out  <= '0;
            r_group_done <= 1'b0;
            r_partial    <= 1'b0;
        end else begin
            r_n          <= w_n;
            r_ptr        <= flush ? '0 : w_post;
            r_valid_out  <= w_onehot;
            r_group_done <= valid_in && w_last;
            // A flush that leaves a nonzero post-write pointer abandons a group.
            r_partial    <= flush && (w_post != '0);
        end
    end

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        byte_striper_n_lane_reg #(
            .DATA_W (DATA_W)
        ) u_lane_reg (
            .clk   (clk),
            .reset (reset),
            .i_we  (w_onehot[k]),
            .i_d   (data_in),
            .o_q   (data_out[k*DATA_W +: DATA_W])
        );
    end

    assign valid_out  = r_valid_out;
    assign lane_ptr   = r_ptr;
    assign group_done = r_group_done;
    assign partial    = r_partial;

endmodule
`default_nettype wire

// File: tb/tb_byte_striper_n.sv
`default_nettype none
// ============================================================================
// Module      : tb_byte_striper_n
// Description : Directed scoreboard bench for byte_striper_n (4 lanes, 8 bit).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_byte_striper_n;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        valid_in = 1'b0;
    logic [7:0]  data_in = 8'h00;
    logic [2:0]  active_lanes = 3'd4;
    logic        flush = 1'b0;
    logic [31:0] data_out;
    logic [3:0]  valid_out;
    logic [1:0]  lane_ptr;
    logic        group_done;
    logic        partial;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int         lane;
        logic [7:0] data;
        bit         gd;
        bit         pt;
    } exp_t;

    exp_t q[$];
    exp_t e;

    byte_striper_n dut (
        .clk          (clk),
        .reset        (reset),
        .valid_in     (valid_in),
        .data_in      (data_in),
        .active_lanes (active_lanes),
        .flush        (flush),
        .data_out     (data_out),
        .valid_out    (valid_out),
        .lane_ptr     (lane_ptr),
        .group_done   (group_done),
        .partial      (partial)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: any visible output event must match the next queued expectation.
    always @(negedge clk) begin
        if (!reset && (valid_out != 4'b0 || group_done || partial)) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: valid_out=%b group_done=%b partial=%b, none expected",
                         valid_out, group_done, partial);
            end else begin
                e = q.pop_front();
                chk("valid_out", 32'(valid_out), (e.lane >= 0) ? 32'(4'b1 << e.lane) : 32'h0);
                if (e.lane >= 0) chk("lane_data", 32'(data_out[e.lane*8 +: 8]), 32'(e.data));
                chk("group_done", 32'(group_done), 32'(e.gd));
                chk("partial", 32'(partial), 32'(e.pt));
            end
        end
    end

    // One clock of stimulus; lane = -1 means no lane write is expected.
    task automatic drive(input bit v, input logic [7:0] d, input bit fl,
                         input int lane, input bit gd, input bit pt);
        exp_t x;
        valid_in = v;
        data_in  = d;
        flush    = fl;
        if (lane >= 0 || gd || pt) begin
            x.lane = lane; x.data = d; x.gd = gd; x.pt = pt;
            q.push_back(x);
        end
        @(posedge clk);
        #1;
        valid_in = 1'b0;
        flush    = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1;
        chk("queue_drained", 32'(q.size()), 32'h0);
        reset = 1'b1;
        #1;
        chk("rst_data_out", data_out, 32'h0);
        chk("rst_valid_out", 32'(valid_out), 32'h0);
        chk("rst_lane_ptr", 32'(lane_ptr), 32'h0);
        chk("rst_group_done", 32'(group_done), 32'h0);
        chk("rst_partial", 32'(partial), 32'h0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        do_reset();

        // Full four-lane stream
        active_lanes = 3'd4;
        for (int i = 0; i < 8; i++)
            drive(1, 8'(8'h10 + i), 0, i % 4, (i % 4) == 3, 0);
        chk("stream4_data", data_out, 32'h17161514);
        chk("stream4_ptr", 32'(lane_ptr), 32'h0);

        // Two active lanes from a clean reset
        do_reset();
        active_lanes = 3'd2;
        for (int i = 0; i < 4; i++)
            drive(1, 8'(8'hA0 + i), 0, i % 2, (i % 2) == 1, 0);
        chk("stream2_data", data_out, 32'h0000A3A2);

        // Lane count change mid-group takes effect only after the wrap
        active_lanes = 3'd4;
        drive(1, 8'hB0, 0, 0, 0, 0);
        active_lanes = 3'd2;
        drive(1, 8'hB1, 0, 1, 0, 0);
        drive(1, 8'hB2, 0, 2, 0, 0);
        drive(1, 8'hB3, 0, 3, 1, 0);
        drive(1, 8'hB4, 0, 0, 0, 0);
        drive(1, 8'hB5, 0, 1, 1, 0);
        chk("nchange_ptr", 32'(lane_ptr), 32'h0);
        chk("nchange_data", data_out, 32'hB3B2B5B4);

        // Flush cases
        active_lanes = 3'd4;
        drive(1, 8'h01, 0, 0, 0, 0);
        drive(1, 8'h02, 0, 1, 0, 0);
        drive(1, 8'h03, 1, 2, 0, 1);
        chk("flush_ptr", 32'(lane_ptr), 32'h0);
        drive(1, 8'h04, 0, 0, 0, 0);
        drive(1, 8'h05, 0, 1, 0, 0);
        drive(1, 8'h06, 0, 2, 0, 0);
        drive(1, 8'h07, 1, 3, 1, 0);
        drive(0, 8'h00, 1, -1, 0, 0);
        drive(1, 8'h08, 0, 0, 0, 0);
        drive(0, 8'h00, 1, -1, 0, 1);
        chk("flush_idle_ptr", 32'(lane_ptr), 32'h0);

        // Gaps between words
        drive(1, 8'h20, 0, 0, 0, 0);
        drive(0, 8'h99, 0, -1, 0, 0);
        chk("gap_valid_out", 32'(valid_out), 32'h0);
        chk("gap_ptr", 32'(lane_ptr), 32'h1);
        chk("gap_hold", 32'(data_out[7:0]), 32'h20);
        drive(1, 8'h21, 0, 1, 0, 0);
        drive(0, 8'h98, 0, -1, 0, 0);
        drive(0, 8'h97, 0, -1, 0, 0);
        drive(1, 8'h22, 0, 2, 0, 0);
        drive(1, 8'h23, 0, 3, 1, 0);
        chk("gap_data", data_out, 32'h23222120);

        // Single active lane
        active_lanes = 3'd1;
        drive(1, 8'h60, 0, 0, 1, 0);
        drive(1, 8'h61, 0, 0, 1, 0);
        chk("n1_data", data_out, 32'h23222161);
        active_lanes = 3'd4;
        drive(1, 8'h62, 0, 0, 0, 0);
        drive(1, 8'h63, 0, 1, 0, 0);
        drive(1, 8'h64, 0, 2, 0, 0);
        chk("midgroup_ptr", 32'(lane_ptr), 32'h3);

        // Async reset mid-group, then illegal request selects all lanes
        do_reset();
        active_lanes = 3'd0;
        drive(1, 8'h55, 0, 0, 0, 0);
        chk("post_rst_data", data_out, 32'h00000055);
        drive(1, 8'h56, 0, 1, 0, 0);
        drive(1, 8'h57, 0, 2, 0, 0);
        drive(1, 8'h58, 0, 3, 1, 0);
        chk("post_rst_ptr", 32'(lane_ptr), 32'h0);

        @(negedge clk);
        #1;
        chk("final_queue", 32'(q.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
